// File: rtl/ring_osc_freq_counter.sv
// ring_osc_freq_counter
//   Measurement stage for a ring oscillator. The block enables the oscillator,
//   waits SETTLE_CYCLES clocks, and then counts rising edges of the
//   resynchronised tap over GATE_CYCLES clocks. The result is a frequency
//   code: f_osc ~= oCount * f_clk / GATE_CYCLES. The tap must be divided
//   upstream so that f_osc < f_clk/4.
//
//   Optional build macro RING_FREQ_CONTINUOUS_EN:
//     When this macro is defined and iStart is high in the final gate cycle,
//     the block starts the next gate window immediately. It does not settle
//     again, and oEnable and oBusy stay high.
//
// Ports:
//   iClk       in   system clock, rising edge
//   iReset_n   in   asynchronous active-low reset (released through 2-FF sync)
//   iStart     in   start request (sampled in IDLE, or at the last gate
//                   cycle in continuous mode)
//   iRingOsc   in   oscillator tap, asynchronous to iClk
//   oEnable    out  ring oscillator enable
//   oCount     out  last measured edge count, held until the next result
//   oValid     out  one-cycle pulse when oCount/oOverflow update
//   oBusy      out  high from an accepted start until the result cycle
//   oOverflow  out  last measurement saturated

module ring_osc_freq_counter #(
    parameter int GATE_CYCLES   = 1000,
    parameter int SETTLE_CYCLES = 8,
    parameter int CNT_W         = 16
) (
    input  logic             iClk,
    input  logic             iReset_n,
    input  logic             iStart,
    input  logic             iRingOsc,
    output logic             oEnable,
    output logic [CNT_W-1:0] oCount,
    output logic             oValid,
    output logic             oBusy,
    output logic             oOverflow
);

    localparam int TMR_MAX = (SETTLE_CYCLES > GATE_CYCLES) ? SETTLE_CYCLES : GATE_CYCLES;
    localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;
    localparam logic [TMR_W-1:0] SETTLE_LAST = TMR_W'(SETTLE_CYCLES - 1);
    localparam logic [TMR_W-1:0] GATE_LAST   = TMR_W'(GATE_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, SETTLE, MEASURE} state_e;

    // Reset is asserted asynchronously and released synchronously.
    logic rst_meta_q, rst_sync_q;

    always_ff @(posedge iClk or negedge iReset_n) begin
        if (!iReset_n) begin
            rst_meta_q <= 1'b0;
            rst_sync_q <= 1'b0;
        end else begin
            rst_meta_q <= 1'b1;
            rst_sync_q <= rst_meta_q;
        end
    end

    // Tap resynchroniser. s3 is one stage behind s2, so s2 & ~s3 marks a
    // rising edge of the tap. The chain runs in every state, and the settle
    // window flushes any stale history before counting starts.
    logic s1_q, s2_q, s3_q;
    logic tap_edge;

    always_ff @(posedge iClk or negedge rst_sync_q) begin
        if (!rst_sync_q) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= iRingOsc;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign tap_edge = s2_q & ~s3_q;

    state_e             state_q, state_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               flag_q, flag_d;
    logic               enable_q, enable_d;
    logic               busy_q, busy_d;
    logic               valid_q, valid_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               ovf_q, ovf_d;

    // The edge counter and flag values after counting this cycle's edge.
    // The result path uses these values so that an edge in the last gate
    // cycle is counted.
    logic [CNT_W-1:0]   cnt_inc;
    logic               flag_inc;

    always_comb begin
        cnt_inc  = cnt_q;
        flag_inc = flag_q;
        if (tap_edge) begin
            if (&cnt_q) flag_inc = 1'b1;
            else        cnt_inc  = cnt_q + 1'b1;
        end
    end

    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        cnt_d    = cnt_q;
        flag_d   = flag_q;
        enable_d = enable_q;
        busy_d   = busy_q;
        valid_d  = 1'b0;
        count_d  = count_q;
        ovf_d    = ovf_q;
        case (state_q)
            IDLE: begin
                if (iStart) begin
                    state_d  = SETTLE;
                    timer_d  = '0;
                    cnt_d    = '0;
                    flag_d   = 1'b0;
                    enable_d = 1'b1;
                    busy_d   = 1'b1;
                end
            end
            SETTLE: begin
                if (timer_q == SETTLE_LAST) begin
                    state_d = MEASURE;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            MEASURE: begin
                cnt_d   = cnt_inc;
                flag_d  = flag_inc;
                timer_d = timer_q + 1'b1;
                if (timer_q == GATE_LAST) begin
                    valid_d = 1'b1;
                    count_d = cnt_inc;
                    ovf_d   = flag_inc;
                    timer_d = '0;
`ifdef RING_FREQ_CONTINUOUS_EN
                    if (iStart) begin
                        // Next window starts immediately. The oscillator is
                        // already running, so no settle is needed.
                        cnt_d  = '0;
                        flag_d = 1'b0;
                    end else begin
                        state_d  = IDLE;
                        enable_d = 1'b0;
                        busy_d   = 1'b0;
                    end
`else
                    state_d  = IDLE;
                    enable_d = 1'b0;
                    busy_d   = 1'b0;
`endif
                end
            end
            default: begin
                state_d  = IDLE;
                enable_d = 1'b0;
                busy_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge iClk or negedge rst_sync_q) begin
        if (!rst_sync_q) begin
            state_q  <= IDLE;
            timer_q  <= '0;
            cnt_q    <= '0;
            flag_q   <= 1'b0;
            enable_q <= 1'b0;
            busy_q   <= 1'b0;
            valid_q  <= 1'b0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            cnt_q    <= cnt_d;
            flag_q   <= flag_d;
            enable_q <= enable_d;
            busy_q   <= busy_d;
            valid_q  <= valid_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    assign oEnable   = enable_q;
    assign oCount    = count_q;
    assign oValid    = valid_q;
    assign oBusy     = busy_q;
    assign oOverflow = ovf_q;

endmodule

// File: tb/tb_ring_osc_freq_counter.sv
module tb_ring_osc_freq_counter;

    localparam int GATE   = 100;
    localparam int SETTLE = 8;
    localparam int CNT_W  = 4;
    localparam int LAT    = SETTLE + GATE;
    localparam int CMAX   = (1 << CNT_W) - 1;

    logic             iClk = 1'b0;
    logic             iReset_n = 1'b1;
    logic             iStart = 1'b0;
    logic             iRingOsc = 1'b0;
    logic             oEnable;
    logic [CNT_W-1:0] oCount;
    logic             oValid;
    logic             oBusy;
    logic             oOverflow;

    ring_osc_freq_counter #(
        .GATE_CYCLES  (GATE),
        .SETTLE_CYCLES(SETTLE),
        .CNT_W        (CNT_W)
    ) dut (
        .iClk     (iClk),
        .iReset_n (iReset_n),
        .iStart   (iStart),
        .iRingOsc (iRingOsc),
        .oEnable  (oEnable),
        .oCount   (oCount),
        .oValid   (oValid),
        .oBusy    (oBusy),
        .oOverflow(oOverflow)
    );

    always #5 iClk = ~iClk;

    // Each expected result holds the count, the overflow flag, the cycle in
    // which oValid must appear, and the oEnable/oBusy level in that cycle.
    typedef struct {
        int cnt;
        int ovf;
        int cyc;
        int busy;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   tap_per = 4;
    int   ph = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d", tag, obs, exp);
        end
    endtask

    always @(posedge iClk) cyc <= cyc + 1;

    // The tap is periodic with a period that divides GATE, so every gate
    // window sees exactly GATE/tap_per rising edges.
    always @(posedge iClk) begin
        #2;
        if (tap_per == 0) begin
            ph = 0;
            iRingOsc = 1'b0;
        end else begin
            ph = (ph + 1) % tap_per;
            iRingOsc = (ph < tap_per / 2);
        end
    end

    always @(negedge iClk) begin
        if (iReset_n && oValid) begin
            if (sb_q.size() == 0) begin
                chk("spurious_valid", 1, 0);
            end else begin
                mon_e = sb_q.pop_front();
                chk("latency", cyc, mon_e.cyc);
                chk("count", int'(oCount), mon_e.cnt);
                chk("overflow", int'(oOverflow), mon_e.ovf);
                chk("en_at_result", int'(oEnable), mon_e.busy);
                chk("busy_at_result", int'(oBusy), mon_e.busy);
            end
        end
    end

    function automatic int exp_cnt(input int p);
        int n;
        n = (p == 0) ? 0 : GATE / p;
        return (n > CMAX) ? CMAX : n;
    endfunction

    function automatic int exp_ovf(input int p);
        return (p != 0 && GATE / p > CMAX) ? 1 : 0;
    endfunction

    task automatic drain();
        for (int i = 0; i < LAT + 4 * GATE && sb_q.size() != 0; i++) @(negedge iClk);
        if (sb_q.size() != 0) begin
            chk("timeout_pending", sb_q.size(), 0);
            sb_q.delete();
        end
    endtask

    task automatic single(input int p, input bit extra);
        exp_t e;
        tap_per = p;
        repeat (5) @(negedge iClk);
        iStart = 1'b1;
        e.cnt = exp_cnt(p);
        e.ovf = exp_ovf(p);
        e.cyc = cyc + 1 + LAT;
        e.busy = 0;
        sb_q.push_back(e);
        @(negedge iClk);
        iStart = 1'b0;
        chk("en_on", int'(oEnable), 1);
        chk("busy_on", int'(oBusy), 1);
        if (extra) begin
            // One pulse lands in SETTLE and one lands in MEASURE. Neither
            // pulse may change the result or its timing.
            repeat (3) @(negedge iClk);
            iStart = 1'b1;
            @(negedge iClk);
            iStart = 1'b0;
            repeat (20) @(negedge iClk);
            iStart = 1'b1;
            @(negedge iClk);
            iStart = 1'b0;
        end
        drain();
        @(negedge iClk);
        chk("en_idle", int'(oEnable), 0);
        chk("busy_idle", int'(oBusy), 0);
    endtask

    initial begin
        int c0;
        int en_lo;
        exp_t e;

        // Reset with the tap toggling.
        #1 iReset_n = 1'b0;
        repeat (3) @(negedge iClk);
        chk("rst_outputs", int'({oEnable, oValid, oBusy, oOverflow, oCount}), 0);
        iReset_n = 1'b1;
        repeat (20) @(negedge iClk);
        chk("idle_outputs", int'({oEnable, oValid, oBusy, oOverflow, oCount}), 0);

        single(10, 1'b0);   // 10 edges
        single(0, 1'b0);    // held low: 0
        single(20, 1'b0);   // 5, overwrites the prior value
        single(4, 1'b0);    // 25 edges saturate: 15 with overflow
        single(0, 1'b0);    // overflow clears again
        single(10, 1'b1);   // extra starts while busy are ignored

        // Reset in the middle of MEASURE.
        chk("count_held", int'(oCount), 10);
        tap_per = 10;
        iStart = 1'b1;
        @(negedge iClk);
        iStart = 1'b0;
        repeat (SETTLE + 40) @(negedge iClk);
        @(posedge iClk);
        #3 iReset_n = 1'b0;
        #1;
        chk("async_en_drop", int'(oEnable), 0);
        chk("async_busy_drop", int'(oBusy), 0);
        chk("async_count_clr", int'(oCount), 0);
        repeat (2) @(negedge iClk);
        iReset_n = 1'b1;
        repeat (LAT + 10) @(negedge iClk);
        chk("post_rst_en", int'(oEnable), 0);
        chk("post_rst_count", int'(oCount), 0);

`ifdef RING_FREQ_CONTINUOUS_EN
        // Hold iStart for three windows, then drop it. One more result
        // follows before the block returns to idle.
        tap_per = 10;
        repeat (5) @(negedge iClk);
        iStart = 1'b1;
        c0 = cyc;
        for (int n = 0; n < 4; n++) begin
            e.cnt = exp_cnt(10);
            e.ovf = 0;
            e.cyc = c0 + 1 + LAT + n * GATE;
            e.busy = (n < 3) ? 1 : 0;
            sb_q.push_back(e);
        end
        en_lo = 0;
        for (int i = 0; i < LAT + 3 * GATE; i++) begin
            @(negedge iClk);
            if (!oEnable) en_lo++;
            if (cyc >= c0 + 1 + LAT + 2 * GATE) break;
        end
        iStart = 1'b0;
        chk("cont_en_low_cycles", en_lo, 0);
        drain();
        @(negedge iClk);
        chk("cont_en_off", int'(oEnable), 0);
        chk("cont_busy_off", int'(oBusy), 0);
`else
        c0 = 0;
        en_lo = 0;
        e.cnt = 0;
`endif

        repeat (5) @(negedge iClk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ring_osc_freq_counter.md
Name: ring_osc_freq_counter

Overview:
Downstream measurement stage for the ring oscillator. It drives the oscillator enable for a fixed settle-plus-gate window, then counts rising edges of one oscillator tap over GATE_CYCLES system clocks. It reports the edge count as a frequency code (f_osc ≈ oCount·f_clk/GATE_CYCLES).
- The oscillator tap is asynchronous to iClk and is resynchronised internally.
- Upstream must divide the tap so that f_osc < f_clk/4.

Parameters:
GATE_CYCLES, 1000, length of counting window in iClk cycles (≥2)
SETTLE_CYCLES, 8, cycles after enable before counting starts (≥4; flushes synchroniser)
CNT_W, 16, width of edge counter / result

Ports:
iClk  input  1  system clock, rising edge
iReset_n  input  1  asynchronous active-low reset
iStart  input  1  start request, sampled in IDLE only
iRingOsc  input  1  oscillator tap, asynchronous
oEnable  output  1  enable to ring oscillator
oCount  output  CNT_W  last measured edge count, held until next result
oValid  output  1  one-cycle pulse: oCount/oOverflow updated
oBusy  output  1  high from accepted start until result cycle
oOverflow  output  1  last measurement saturated

Behaviour:
- Reset is asynchronous and active-low. It is asserted asynchronously and released synchronously via a 2-FF reset synchroniser.
- Reset values: oEnable=0, oCount=0, oValid=0, oBusy=0, oOverflow=0, state=IDLE, synchroniser FFs=0, counters=0.
- Reset mid-operation: oEnable drops immediately. No oValid is issued. The prior oCount is lost (it becomes 0).
- Synchroniser: s1←iRingOsc, s2←s1, s3←s2, running every cycle in all states. The edge condition is s2 & ~s3.
- FSM states IDLE, SETTLE, MEASURE. All outputs are registered.
- IDLE:
  - iStart=1 → SETTLE. Next cycle: oEnable=1, oBusy=1, timer=0, edge counter=0, overflow flag=0.
- SETTLE:
  - Edges are ignored.
  - After SETTLE_CYCLES cycles (timer==SETTLE_CYCLES-1) → MEASURE, timer=0.
- MEASURE:
  - Each cycle with the edge condition increments the edge counter.
  - At all-ones the counter saturates and the sticky overflow flag is set.
  - An edge in the final cycle (timer==GATE_CYCLES-1) is counted.
  - After the final cycle → IDLE.
- Result cycle (first cycle after the final MEASURE cycle):
  - oCount=final count, oOverflow=flag, oValid=1.
  - oEnable=0, oBusy=0.
  - oValid is 0 in every other cycle.
- Latency: iStart sampled at edge k gives oValid high in cycle k+1+SETTLE_CYCLES+GATE_CYCLES.
- iStart while busy is ignored and not queued. iStart high in the result cycle is accepted (state is IDLE).
- Timers are sized to max(SETTLE_CYCLES, GATE_CYCLES). There is no wrap inside a window.

Optional Feature:
RING_FREQ_CONTINUOUS_EN
- Defined:
  - At the final MEASURE cycle, if iStart=1, the FSM re-enters MEASURE directly. The edge counter is cleared, oEnable stays 1, oBusy stays 1, and no re-settle occurs.
  - oValid pulses every GATE_CYCLES cycles. An edge in the result cycle belongs to the new window.
  - If iStart=0 at the final cycle, behaviour is as single-shot (→ IDLE).
- Undefined: single-shot only, as above. iStart is never sampled outside IDLE.

Test Plan:
1. Assert iReset_n=0 with iRingOsc toggling → all outputs 0. Release, idle 20 cycles → outputs remain 0, oEnable=0.
2. GATE_CYCLES=100, SETTLE_CYCLES=8, iRingOsc period 10 clk, iStart pulse at cycle k → oEnable=1 from k+1 to k+108. oValid=1 only at k+109, oCount=10 (±1), oOverflow=0, oBusy falls at k+109.
3. iRingOsc held 0, one start → oCount=0, oOverflow=0, oValid once. Then a second start with period 20 clk → oCount=5 (±1), overwriting the prior value.
4. CNT_W=4, GATE_CYCLES=100, iRingOsc period 4 clk → oCount=15, oOverflow=1. A following run with iRingOsc held 0 → oOverflow=0.
5. Extra iStart pulses during SETTLE/MEASURE → single oValid at the original latency. Then iReset_n=0 for 2 cycles mid-MEASURE → oEnable=0 asynchronously, no oValid, oCount=0.
6. With RING_FREQ_CONTINUOUS_EN, GATE_CYCLES=50, iStart held 1, period 10 clk → oValid every 50 cycles with oCount=5 (±1) and oEnable continuously 1. Drop iStart → one further result, then oEnable=0 and oBusy=0.
